fetch_unit: RTL
===============

Name: fetch_unit

Overview:
IF stage plus IF/ID pipeline register for the 5-stage RV32 core. It owns the PC, issues word reads to the synchronous instruction SRAM, and registers {pc, instr, valid} into IF/ID. It obeys the pc_write / instr_flush / ifid_regwrite controls from the hazard controller and the branch redirect from EX. A one-entry hold buffer keeps an in-flight SRAM word intact across load-use stalls.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset.
NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) written into IF/ID on reset, flush and bubble.

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst  in  1  asynchronous active-low reset
pc_write  in  1  1 = PC may advance; 0 = hold PC (stall)
instr_flush  in  1  1 = squash IF/ID and the in-flight fetch
ifid_regwrite  in  1  1 = IF/ID may load; 0 = hold IF/ID
redirect_valid  in  1  branch/jump taken in EX (BranchCtrl != 2'b00)
redirect_pc  in  32  branch/jump target
im_ready  in  1  instruction SRAM accepts a read this cycle
im_cs  out  1  read strobe
im_addr  out  32  byte address, bits [1:0] always 0
im_rdata  in  32  SRAM data; valid exactly one cycle after an accepted read
ifid_pc  out  32  PC of the IF/ID instruction
ifid_instr  out  32  IF/ID instruction
ifid_valid  out  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset (rst=0, async): pc_q=RESET_PC, slot_v=0, hold_v=0, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0, im_cs=0.
- Slot: the one outstanding fetch. It holds slot_v, slot_pc and hold_v/hold_instr. Slot data is im_rdata when hold_v=0 and hold_instr when hold_v=1.
- issue = im_ready & pc_write & ifid_regwrite & ~redirect_valid & ~instr_flush.
- im_cs = issue and im_addr = pc_q, both combinational.
- Priority per cycle, highest first:
  1. redirect_valid: IF/ID <= {0, NOP_INSTR, 0}; slot_v<=0, hold_v<=0; pc_q <= {redirect_pc[31:2], 2'b00}. This applies regardless of the other controls.
  2. instr_flush (no redirect): IF/ID <= bubble; slot and hold are killed; pc_q unchanged.
  3. ifid_regwrite=1: IF/ID <= slot_v ? {slot_pc, slot data, 1} : bubble. hold_v<=0. slot_v<=issue and slot_pc<=pc_q. If issue, pc_q <= pc_q+4, wrapping modulo 2^32.
  4. ifid_regwrite=0 (stall): IF/ID holds and pc_q holds. If slot_v & ~hold_v: hold_instr<=im_rdata, hold_v<=1. Otherwise the slot is unchanged.
- pc_write=1 with ifid_regwrite=0 is never produced upstream. It is defined as a plain stall and the PC does not advance.
- im_ready=0: no issue and the PC holds. An existing slot still completes into IF/ID normally. IF/ID receives a bubble on the following cycle.
- Latency: the first im_cs is asserted in the first cycle after reset release. The first ifid_valid=1 appears one cycle later. Steady-state throughput is 1 instr/cycle.
- Redirect penalty: the slot is killed. Target data reaches IF/ID 2 cycles after the redirect edge.
- Reset mid-stall or mid-fetch discards slot and hold immediately.

Decomposition:
- Shared package core_pkg:
  - NOP_INSTR constant
  - RESET_PC default
  - branch_ctrl_e enum (NONE=00, B=01, JALR=10, J=11), shared with the hazard controller
  - ifid_t struct {pc, instr, valid}
- One sub-module, fetch_hold_buf: slot_v/slot_pc/hold_v/hold_instr and the data mux.
- PC logic and IF/ID register stay in fetch_unit.

Test Plan:
- Reset then free-run with im_ready=1, SRAM returning addr as data:
  - im_addr sequence is 0,4,8.
  - ifid_valid rises at cycle 2 with pc=0, instr=0.
  - ifid_pc then increments by 4 every cycle.
- Load-use stall of 2 cycles with pc_write=0, ifid_regwrite=0 while the slot for pc=0x10 is in flight, and the SRAM drives garbage after cycle 1:
  - IF/ID holds.
  - After release, IF/ID = {0x10, original word, 1} and im_addr resumes at 0x14 with no skipped or duplicated PC.
- Redirect to 0x0000_0103 while the slot for 0x20 is in flight:
  - IF/ID becomes a bubble and the slot is dropped.
  - Next im_addr = 0x100; IF/ID = {0x100, data, 1} 2 cycles later.
- im_ready=0 for 3 cycles:
  - im_cs=0 throughout and pc_q is held.
  - IF/ID receives 3 bubbles after the pending slot drains.
  - Fetch resumes at the held PC.
- PC wrap: redirect to 0xFFFF_FFFC, then run 2 cycles -> im_addr = 0xFFFF_FFFC, then 0x0000_0000.
- Assert rst=0 asynchronously mid-stall with hold_v=1 -> outputs reach reset values before the next edge; the first fetch after release is at RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Types and constants shared by the RV32 pipeline front end and the hazard
// controller.
//   NOP_INSTR_DEF  : canonical bubble instruction (addi x0,x0,0)
//   RESET_PC_DEF   : default reset vector
//   branch_ctrl_e  : EX-stage branch control encoding
//   ifid_t         : IF/ID pipeline register contents
// ---------------------------------------------------------------------------
package core_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_B    = 2'b01,
    BR_JALR = 2'b10,
    BR_J    = 2'b11
  } branch_ctrl_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  // IF/ID contents for an empty pipeline slot.
  function automatic ifid_t ifid_bubble(input logic [31:0] nop);
    ifid_t b;
    b.pc    = 32'h0000_0000;
    b.instr = nop;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// ---------------------------------------------------------------------------
// fetch_hold_buf
// Tracks the single outstanding instruction fetch ("slot") and captures the
// SRAM word when IF/ID is stalled, because the SRAM only presents read data
// for one cycle after the accepted read.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   kill           : drop slot and hold (redirect or flush)
//   advance        : IF/ID loads this cycle (slot is consumed)
//   issue          : a new read is accepted this cycle
//   fetch_pc       : address of the read being issued
//   rdata          : SRAM read data
//   slot_v         : slot holds an outstanding fetch
//   slot_pc        : PC of the outstanding fetch
//   slot_data      : instruction word belonging to the slot
// ---------------------------------------------------------------------------
module fetch_hold_buf
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        kill,
  input  logic        advance,
  input  logic        issue,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] rdata,
  output logic        slot_v,
  output logic [31:0] slot_pc,
  output logic [31:0] slot_data
);

  logic        hold_v;
  logic [31:0] hold_instr;

  // Control state: valid bits only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_v <= 1'b0;
      hold_v <= 1'b0;
    end else if (kill) begin
      slot_v <= 1'b0;
      hold_v <= 1'b0;
    end else if (advance) begin
      slot_v <= issue;
      hold_v <= 1'b0;
    end else if (slot_v && !hold_v) begin
      // First stalled cycle: the SRAM word is on rdata now and gone next cycle.
      hold_v <= 1'b1;
    end
  end

  // Data state: no reset needed, always qualified by slot_v / hold_v.
  always_ff @(posedge clk) begin
    if (!kill && advance) begin
      slot_pc <= fetch_pc;
    end
    if (!kill && !advance && slot_v && !hold_v) begin
      hold_instr <= rdata;
    end
  end

  assign slot_data = hold_v ? hold_instr : rdata;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// IF stage and IF/ID pipeline register of the 5-stage RV32 core. Owns the PC,
// issues word reads to the synchronous instruction SRAM and registers
// {pc, instr, valid} into IF/ID under hazard-controller and EX redirect
// control.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   pc_write        : PC may advance (0 = stall)
//   instr_flush     : squash IF/ID and the in-flight fetch
//   ifid_regwrite   : IF/ID may load (0 = hold)
//   redirect_valid  : taken branch/jump in EX
//   redirect_pc     : branch/jump target
//   im_ready        : SRAM accepts a read this cycle
//   im_cs, im_addr  : SRAM read strobe and word-aligned byte address
//   im_rdata        : SRAM data, valid one cycle after an accepted read
//   ifid_pc, ifid_instr, ifid_valid : IF/ID register outputs
// ---------------------------------------------------------------------------
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        instr_flush,
  input  logic        ifid_regwrite,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        im_ready,
  output logic        im_cs,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid
);

  logic [31:0] pc_q;
  logic        issue;
  logic        kill;
  logic        slot_v;
  logic [31:0] slot_pc;
  logic [31:0] slot_data;
  ifid_t       ifid_q;
  logic        unused_redirect_lsb;

  // Targets are forced to word alignment; the low bits are ignored.
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign kill  = redirect_valid | instr_flush;
  assign issue = im_ready & pc_write & ifid_regwrite & ~kill;

  // Strobe is gated by reset so the SRAM sees no read while held in reset.
  assign im_cs   = issue & rst;
  assign im_addr = pc_q;

  fetch_hold_buf u_hold (
    .clk       (clk),
    .rst       (rst),
    .kill      (kill),
    .advance   (ifid_regwrite),
    .issue     (issue),
    .fetch_pc  (pc_q),
    .rdata     (im_rdata),
    .slot_v    (slot_v),
    .slot_pc   (slot_pc),
    .slot_data (slot_data)
  );

  // IF stage: program counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[31:2], 2'b00};
    end else if (issue) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // IF/ID boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_q <= ifid_bubble(NOP_INSTR);
    end else if (kill) begin
      ifid_q <= ifid_bubble(NOP_INSTR);
    end else if (ifid_regwrite) begin
      if (slot_v) begin
        ifid_q.pc    <= slot_pc;
        ifid_q.instr <= slot_data;
        ifid_q.valid <= 1'b1;
      end else begin
        ifid_q <= ifid_bubble(NOP_INSTR);
      end
    end
  end

  assign ifid_pc    = ifid_q.pc;
  assign ifid_instr = ifid_q.instr;
  assign ifid_valid = ifid_q.valid;

endmodule
